cpu_fetch: RTL and testbench

Instruction fetch stage: the producer of `fetch_data_t` for the decode stage. It owns the program counter and reads 32-bit instructions over the instruction bus with a request/ready handshake. It extracts the register index fields, zeroing any field the instruction format does not use, so that decode can derive `have_rs` by OR-reduction. It publishes each new instruction by toggling `strobe`, and it redirects on jumps from execute.

---
 rtl/cpu_fetch.sv | 214 +++++++++++++++++++++
 tb/tb_cpu_fetch.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_fetch
//  Brief    : Instruction fetch stage; owns the PC, reads instructions over a
//             request/ready bus and publishes them to decode via a strobe.
//  Revision : 1.0 - initial release
// ============================================================================

package cpu_fetch_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
        logic [4:0]  inst_rs1;
        logic [4:0]  inst_rs2;
        logic [4:0]  inst_rs3;
        logic [4:0]  inst_rd;
        logic        strobe;
    } fetch_data_t;
endpackage

module cpu_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic                       i_reset,
    input  logic                       i_clock,
    output logic                       o_fault,
    output logic                       o_bus_request,
    output logic [31:0]                o_bus_address,
    input  logic                       i_bus_ready,
    input  logic [31:0]                i_bus_rdata,
    input  logic                       i_busy,
    input  logic                       i_jump,
    input  logic [31:0]                i_jump_pc,
    output cpu_fetch_pkg::fetch_data_t o_data
);

    localparam logic [2:0] S_RESET   = 3'd0;
    localparam logic [2:0] S_REQUEST = 3'd1;
    localparam logic [2:0] S_DISCARD = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_FAULT   = 3'd4;

    logic [2:0]                 r_state;
    logic [2:0]                 w_state_next;
    logic [31:0]                r_pc;
    logic [31:0]                w_pc_next;
    logic [31:0]                r_target;
    logic [31:0]                w_target_next;
    logic                       r_bus_request;
    logic                       w_bus_request_next;
    logic                       r_fault;
    logic                       w_fault_next;
    logic                       w_accept;
    logic                       w_jump_bad;
    cpu_fetch_pkg::fetch_data_t r_data;
    cpu_fetch_pkg::fetch_data_t w_data_next;

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic [4:0] w_rs3;
    logic [4:0] w_rd;

    assign w_jump_bad = i_jump && (i_jump_pc[1:0] != 2'b00);
    assign w_opcode   = i_bus_rdata[6:0];
    assign w_funct3   = i_bus_rdata[14:12];

    // Unused fields stay zero so decode can OR-reduce them into have_rs.
    always_comb begin : p_fields
        w_rs1 = 5'd0;
        w_rs2 = 5'd0;
        w_rs3 = 5'd0;
        w_rd  = 5'd0;
        case (w_opcode)
            7'b0110111, 7'b0010111, 7'b1101111: begin
                w_rd = i_bus_rdata[11:7];
            end
            7'b1100111, 7'b0000011, 7'b0010011: begin
                w_rs1 = i_bus_rdata[19:15];
                w_rd  = i_bus_rdata[11:7];
            end
            7'b1100011, 7'b0100011: begin
                w_rs1 = i_bus_rdata[19:15];
                w_rs2 = i_bus_rdata[24:20];
            end
            7'b0110011: begin
                w_rs1 = i_bus_rdata[19:15];
                w_rs2 = i_bus_rdata[24:20];
                w_rd  = i_bus_rdata[11:7];
            end
            7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111: begin
                w_rs1 = i_bus_rdata[19:15];
                w_rs2 = i_bus_rdata[24:20];
                w_rs3 = i_bus_rdata[31:27];
                w_rd  = i_bus_rdata[11:7];
            end
            7'b1110011: begin
                if (w_funct3 != 3'b000) begin
                    w_rd = i_bus_rdata[11:7];
                    if (!w_funct3[2]) begin
                        w_rs1 = i_bus_rdata[19:15];
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge i_clock) begin : p_state_reg
        if (i_reset) begin
            r_state       <= S_RESET;
            r_pc          <= RESET_VECTOR;
            r_target      <= RESET_VECTOR;
            r_bus_request <= 1'b0;
            r_fault       <= 1'b0;
            r_data        <= '0;
        end else begin
            r_state       <= w_state_next;
            r_pc          <= w_pc_next;
            r_target      <= w_target_next;
            r_bus_request <= w_bus_request_next;
            r_fault       <= w_fault_next;
            r_data        <= w_data_next;
        end
    end

    always_comb begin : p_next_state
        w_state_next  = r_state;
        w_pc_next     = r_pc;
        w_target_next = r_target;
        w_fault_next  = r_fault;
        w_accept      = 1'b0;
        case (r_state)
            S_RESET: begin
                w_state_next = S_REQUEST;
            end
            S_REQUEST: begin
                if (w_jump_bad) begin
                    w_state_next = S_FAULT;
                    w_fault_next = 1'b1;
                end else if (i_jump) begin
                    // A read cannot be cancelled: finish it, then drop its data.
                    if (i_bus_ready) begin
                        w_pc_next = i_jump_pc;
                    end else begin
                        w_target_next = i_jump_pc;
                        w_state_next  = S_DISCARD;
                    end
                end else if (i_bus_ready) begin
                    w_accept     = 1'b1;
                    w_pc_next    = r_pc + 32'd4;
                    w_state_next = i_busy ? S_WAIT : S_REQUEST;
                end
            end
            S_DISCARD: begin
                if (w_jump_bad) begin
                    w_state_next = S_FAULT;
                    w_fault_next = 1'b1;
                end else begin
                    if (i_jump) begin
                        w_target_next = i_jump_pc;
                    end
                    if (i_bus_ready) begin
                        w_pc_next    = i_jump ? i_jump_pc : r_target;
                        w_state_next = S_REQUEST;
                    end
                end
            end
            S_WAIT: begin
                if (w_jump_bad) begin
                    w_state_next = S_FAULT;
                    w_fault_next = 1'b1;
                end else begin
                    if (i_jump) begin
                        w_pc_next = i_jump_pc;
                    end
                    if (!i_busy) begin
                        w_state_next = S_REQUEST;
                    end
                end
            end
            S_FAULT: begin
            end
            default: begin
                w_state_next = S_RESET;
            end
        endcase
    end

    always_comb begin : p_outputs
        // In FAULT an in-flight read is still held until the bus completes it.
        w_bus_request_next = (w_state_next == S_REQUEST) || (w_state_next == S_DISCARD) ||
                             ((w_state_next == S_FAULT) && r_bus_request && !i_bus_ready);
        w_data_next = r_data;
        if (w_accept) begin
            w_data_next.pc          = r_pc;
            w_data_next.instruction = i_bus_rdata;
            w_data_next.inst_rs1    = w_rs1;
            w_data_next.inst_rs2    = w_rs2;
            w_data_next.inst_rs3    = w_rs3;
            w_data_next.inst_rd     = w_rd;
            w_data_next.strobe      = ~r_data.strobe;
        end
    end

    assign o_fault       = r_fault;
    assign o_bus_request = r_bus_request;
    assign o_bus_address = r_pc;
    assign o_data        = r_data;

endmodule
`default_nettype wire

// File: tb/tb_cpu_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_fetch
//  Brief    : Self-checking bench for cpu_fetch against a transaction model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_fetch;
    import cpu_fetch_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        fault;
    logic        bus_request;
    logic [31:0] bus_address;
    logic        bus_ready = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        busy = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] jump_pc = '0;
    fetch_data_t data;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_pc;
    logic        exp_strobe;
    fetch_data_t exp_data;
    fetch_data_t saved;

    cpu_fetch #(.RESET_VECTOR(32'h0000_0100)) dut (
        .i_reset(reset), .i_clock(clock), .o_fault(fault),
        .o_bus_request(bus_request), .o_bus_address(bus_address),
        .i_bus_ready(bus_ready), .i_bus_rdata(bus_rdata), .i_busy(busy),
        .i_jump(jump), .i_jump_pc(jump_pc), .o_data(data)
    );

    always #5 clock = ~clock;

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    // Reference: which register fields an opcode carries, from the ISA formats.
    function automatic fetch_data_t model(input logic [31:0] pc, input logic [31:0] w,
                                          input logic strobe);
        fetch_data_t d;
        bit u1, u2, u3, ud;
        logic [6:0] op;
        logic [2:0] f3;
        op = w[6:0];
        f3 = w[14:12];
        u1 = 0; u2 = 0; u3 = 0; ud = 0;
        if (op inside {7'h37, 7'h17, 7'h6F})             ud = 1;
        else if (op inside {7'h67, 7'h03, 7'h13})        begin u1 = 1; ud = 1; end
        else if (op inside {7'h63, 7'h23})               begin u1 = 1; u2 = 1; end
        else if (op == 7'h33)                            begin u1 = 1; u2 = 1; ud = 1; end
        else if (op inside {7'h43, 7'h47, 7'h4B, 7'h4F}) begin u1 = 1; u2 = 1; u3 = 1; ud = 1; end
        else if (op == 7'h73 && f3 != 3'd0)              begin ud = 1; u1 = !f3[2]; end
        d.pc          = pc;
        d.instruction = w;
        d.inst_rs1    = u1 ? w[19:15] : 5'd0;
        d.inst_rs2    = u2 ? w[24:20] : 5'd0;
        d.inst_rs3    = u3 ? w[31:27] : 5'd0;
        d.inst_rd     = ud ? w[11:7]  : 5'd0;
        d.strobe      = strobe;
        return d;
    endfunction

    // Bus responder: waits (bounded) for a request, inserts wait states, then completes it.
    task automatic serve(input logic [31:0] word, input int waits,
                         output logic [31:0] addr, output bit timed_out);
        int n;
        n = 0;
        timed_out = 0;
        addr = '0;
        while (!bus_request && n < 20) begin
            cycle();
            n++;
        end
        if (!bus_request) begin
            timed_out = 1;
            return;
        end
        addr = bus_address;
        bus_ready = 1'b0;
        repeat (waits) begin
            bus_rdata = $urandom;
            cycle();
        end
        bus_ready = 1'b1;
        bus_rdata = word;
        cycle();
        bus_ready = 1'b0;
        bus_rdata = $urandom;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) cycle();
        checks++; if (bus_request !== 1'b0) begin errors++; $display("FAIL reset_request got=%b want=0", bus_request); end
        checks++; if (bus_address !== 32'h100) begin errors++; $display("FAIL reset_address got=%h want=00000100", bus_address); end
        checks++; if (data !== '0) begin errors++; $display("FAIL reset_data got=%h want=0", data); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got=%b want=0", fault); end
        reset = 1'b0;
        checks++; if (bus_request !== 1'b0) begin errors++; $display("FAIL first_cycle_request got=%b want=0", bus_request); end
        cycle();
        checks++; if (bus_request !== 1'b1 || bus_address !== 32'h100) begin
            errors++; $display("FAIL second_cycle_request got=%b@%h want=1@00000100", bus_request, bus_address);
        end
        exp_pc = 32'h100;
        exp_strobe = 1'b0;
    endtask

    task automatic test_fields();
        logic [31:0] words [5];
        logic [31:0] a;
        bit to;
        words = '{32'h00500093, 32'h00208663, 32'h203100C3, 32'h3400D073, 32'h34029073};
        foreach (words[i]) begin
            serve(words[i], 0, a, to);
            checks++; if (to || a !== exp_pc) begin errors++; $display("FAIL fields_addr[%0d] got=%h want=%h timeout=%0d", i, a, exp_pc, to); end
            exp_strobe = ~exp_strobe;
            exp_data = model(exp_pc, words[i], exp_strobe);
            checks++; if (data !== exp_data) begin errors++; $display("FAIL fields_data[%0d] got=%h want=%h", i, data, exp_data); end
            exp_pc += 4;
            checks++; if (bus_request !== 1'b1 || bus_address !== exp_pc) begin
                errors++; $display("FAIL fields_next_req[%0d] got=%b@%h want=1@%h", i, bus_request, bus_address, exp_pc);
            end
            if (i == 0) begin
                checks++; if (data.pc !== 32'h100 || data.inst_rd !== 5'd1 || data.inst_rs1 !== 5'd0 || data.strobe !== 1'b1) begin
                    errors++; $display("FAIL addi_fields got pc=%h rd=%0d rs1=%0d strobe=%b want pc=100 rd=1 rs1=0 strobe=1",
                                       data.pc, data.inst_rd, data.inst_rs1, data.strobe);
                end
            end
            if (i == 2) begin
                checks++; if (data.inst_rs3 !== 5'd4 || data.inst_rs2 !== 5'd3 || data.inst_rs1 !== 5'd2 || data.inst_rd !== 5'd1) begin
                    errors++; $display("FAIL r4_fields got rs3=%0d rs2=%0d rs1=%0d rd=%0d want 4 3 2 1",
                                       data.inst_rs3, data.inst_rs2, data.inst_rs1, data.inst_rd);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [6:0]  ops [16];
        logic [31:0] w;
        logic [31:0] a;
        bit to;
        bit b;
        int hold;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h63, 7'h23,
                7'h33, 7'h43, 7'h47, 7'h4B, 7'h4F, 7'h73, 7'h0F, 7'h7F};
        for (int i = 0; i < 40; i++) begin
            w = {$urandom, ops[$urandom_range(0, 15)]};
            w[6:0] = ops[$urandom_range(0, 15)];
            b = ($urandom_range(0, 3) == 0);
            busy = b;
            serve(w, $urandom_range(0, 2), a, to);
            checks++; if (to || a !== exp_pc) begin errors++; $display("FAIL rand_addr[%0d] got=%h want=%h timeout=%0d", i, a, exp_pc, to); end
            exp_strobe = ~exp_strobe;
            exp_data = model(exp_pc, w, exp_strobe);
            checks++; if (data !== exp_data) begin errors++; $display("FAIL rand_data[%0d] got=%h want=%h", i, data, exp_data); end
            exp_pc += 4;
            if (b) begin
                hold = $urandom_range(1, 3);
                for (int k = 0; k < hold; k++) begin
                    checks++; if (bus_request !== 1'b0 || data.strobe !== exp_strobe) begin
                        errors++; $display("FAIL rand_busy[%0d] got req=%b strobe=%b want req=0 strobe=%b", i, bus_request, data.strobe, exp_strobe);
                    end
                    cycle();
                end
                busy = 1'b0;
                cycle();
            end
        end
        busy = 1'b0;
    endtask

    task automatic test_busy();
        logic [31:0] w;
        logic [31:0] a;
        bit to;
        w = 32'h00C58533;
        busy = 1'b1;
        serve(w, 1, a, to);
        exp_strobe = ~exp_strobe;
        exp_data = model(exp_pc, w, exp_strobe);
        checks++; if (to || data !== exp_data) begin errors++; $display("FAIL busy_accept got=%h want=%h timeout=%0d", data, exp_data, to); end
        exp_pc += 4;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) cycle();
            checks++; if (bus_request !== 1'b0 || data.strobe !== exp_strobe) begin
                errors++; $display("FAIL busy_hold[%0d] got req=%b strobe=%b want req=0 strobe=%b", k, bus_request, data.strobe, exp_strobe);
            end
        end
        busy = 1'b0;
        cycle();
        checks++; if (bus_request !== 1'b1 || bus_address !== exp_pc || data.strobe !== exp_strobe) begin
            errors++; $display("FAIL busy_resume got=%b@%h strobe=%b want=1@%h strobe=%b", bus_request, bus_address, data.strobe, exp_pc, exp_strobe);
        end
    endtask

    task automatic test_jump();
        logic [31:0] w;
        logic [31:0] a;
        bit to;
        int n;
        n = 0;
        while (!bus_request && n < 20) begin cycle(); n++; end
        checks++; if (bus_request !== 1'b1 || bus_address !== exp_pc) begin
            errors++; $display("FAIL jump_pre got=%b@%h want=1@%h", bus_request, bus_address, exp_pc);
        end
        saved = data;
        bus_ready = 1'b0;
        jump = 1'b1;
        jump_pc = 32'h200;
        cycle();
        jump = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++; if (bus_request !== 1'b1 || bus_address !== exp_pc) begin
                errors++; $display("FAIL discard_hold[%0d] got=%b@%h want=1@%h", k, bus_request, bus_address, exp_pc);
            end
            cycle();
        end
        bus_ready = 1'b1;
        bus_rdata = $urandom;
        cycle();
        bus_ready = 1'b0;
        checks++; if (data !== saved) begin errors++; $display("FAIL discard_drop got=%h want=%h", data, saved); end
        checks++; if (bus_request !== 1'b1 || bus_address !== 32'h200) begin
            errors++; $display("FAIL discard_target got=%b@%h want=1@00000200", bus_request, bus_address);
        end
        // Jump coinciding with ready.
        bus_ready = 1'b1;
        bus_rdata = $urandom;
        jump = 1'b1;
        jump_pc = 32'h300;
        cycle();
        bus_ready = 1'b0;
        jump = 1'b0;
        checks++; if (data !== saved || bus_request !== 1'b1 || bus_address !== 32'h300) begin
            errors++; $display("FAIL jump_with_ready got data=%h req=%b@%h want data=%h req=1@00000300", data, bus_request, bus_address, saved);
        end
        exp_pc = 32'h300;
        // Jump while stalled by busy.
        w = 32'h0000A283;
        busy = 1'b1;
        serve(w, 0, a, to);
        exp_strobe = ~exp_strobe;
        exp_data = model(exp_pc, w, exp_strobe);
        checks++; if (to || data !== exp_data) begin errors++; $display("FAIL wait_accept got=%h want=%h timeout=%0d", data, exp_data, to); end
        jump = 1'b1;
        jump_pc = 32'hFFFF_FFFC;
        cycle();
        jump = 1'b0;
        busy = 1'b0;
        checks++; if (bus_request !== 1'b0) begin errors++; $display("FAIL wait_jump_idle got=%b want=0", bus_request); end
        cycle();
        checks++; if (bus_request !== 1'b1 || bus_address !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL wait_jump_target got=%b@%h want=1@fffffffc", bus_request, bus_address);
        end
        exp_pc = 32'hFFFF_FFFC;
    endtask

    task automatic test_wrap();
        logic [31:0] w;
        logic [31:0] a;
        bit to;
        w = 32'h123452B7;
        serve(w, 0, a, to);
        exp_strobe = ~exp_strobe;
        exp_data = model(exp_pc, w, exp_strobe);
        checks++; if (to || data !== exp_data) begin errors++; $display("FAIL wrap_data got=%h want=%h timeout=%0d", data, exp_data, to); end
        exp_pc += 4;
        checks++; if (bus_request !== 1'b1 || bus_address !== exp_pc || exp_pc !== 32'h0) begin
            errors++; $display("FAIL wrap_address got=%b@%h want=1@00000000", bus_request, bus_address);
        end
    endtask

    task automatic test_fault();
        bit bad;
        saved = data;
        bus_ready = 1'b0;
        jump = 1'b1;
        jump_pc = 32'h202;
        cycle();
        jump = 1'b0;
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL fault_set got=%b want=1", fault); end
        checks++; if (bus_request !== 1'b1) begin errors++; $display("FAIL fault_inflight got=%b want=1", bus_request); end
        bus_ready = 1'b1;
        bus_rdata = $urandom;
        cycle();
        bus_ready = 1'b0;
        checks++; if (bus_request !== 1'b0 || data !== saved) begin
            errors++; $display("FAIL fault_drop got req=%b data=%h want req=0 data=%h", bus_request, data, saved);
        end
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            bus_ready = $urandom_range(0, 1);
            jump = $urandom_range(0, 1);
            jump_pc = $urandom & 32'hFFFF_FFFC;
            cycle();
            if (bus_request !== 1'b0 || fault !== 1'b1 || data !== saved) bad = 1;
        end
        bus_ready = 1'b0;
        jump = 1'b0;
        checks++; if (bad) begin errors++; $display("FAIL fault_idle got req=%b fault=%b want req=0 fault=1", bus_request, fault); end
        reset = 1'b1;
        cycle();
        checks++; if (fault !== 1'b0 || bus_request !== 1'b0 || data !== '0) begin
            errors++; $display("FAIL fault_reset got fault=%b req=%b data=%h want 0 0 0", fault, bus_request, data);
        end
    endtask

    task automatic test_reset_mid();
        reset = 1'b0;
        cycle();
        checks++; if (bus_request !== 1'b1 || bus_address !== 32'h100) begin
            errors++; $display("FAIL mid_pre got=%b@%h want=1@00000100", bus_request, bus_address);
        end
        reset = 1'b1;
        bus_ready = 1'b1;
        bus_rdata = 32'h00500093;
        cycle();
        bus_ready = 1'b0;
        checks++; if (data !== '0 || bus_request !== 1'b0 || bus_address !== 32'h100) begin
            errors++; $display("FAIL mid_abort got data=%h req=%b@%h want data=0 req=0@00000100", data, bus_request, bus_address);
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fields();
        test_random();
        test_busy();
        test_jump();
        test_wrap();
        test_fault();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
